i2c_target_regfile: RTL and testbench

Parametrised I2C target (peripheral) that oversamples SCL/SDA on the system clock and exposes a byte-wide register-file port to local logic. Supports addressed writes and reads, a register pointer with auto-increment and wrap, repeated START, and an open-drain SDA driver. Sits between the board-level I2C pins and a local register bank or FIFO.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_bus_sync.sv | 46 ++++
 rtl/i2c_target_regfile.sv | 176 +++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C target register-file block.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises the asynchronous SCL/SDA pads and derives single-cycle
// edge, START and STOP pulses from the synchronised levels.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_h;
  logic                   sda_h;

  // Idle bus is high on both lines, so reset to 1 to avoid a false START.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_h    <= 1'b1;
      sda_h    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_h    <= scl_s;
      sda_h    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_h;
  assign scl_fall = ~scl_s & scl_h;
  // SDA may only move while SCL is low, except for START/STOP.
  assign start    = scl_s & scl_h & sda_h & ~sda_s;
  assign stop     = scl_s & scl_h & ~sda_h & sda_s;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a register pointer (auto-increment, wrap) that exposes
// byte-wide write/read strobes to a local register bank.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h2A,
  parameter int         DEPTH       = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        PTR_W       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic [PTR_W-1:0] reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_wr_en,
  input  logic [7:0]       reg_rdata,
  output logic             reg_rd_en,
  output logic             busy
);

  logic unused_scl_s;
  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_s    (unused_scl_s),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_e       state, state_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n;
  logic [PTR_W-1:0] ptr, ptr_n;
  logic             sda_oe_n, busy_n, rw, rw_n, wr_en_n, load_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      rw        <= RW_WRITE;
      reg_wr_en <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      ptr       <= ptr_n;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      rw        <= rw_n;
      reg_wr_en <= wr_en_n;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    rw_n      = rw;
    wr_en_n   = 1'b0;
    load_rd   = 1'b0;
    reg_rd_en = 1'b0;

    // Post-increment after the write strobe has presented the old pointer.
    if (reg_wr_en) ptr_n = ptr + PTR_W'(1);

    if (start) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else if (stop) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise && bit_cnt != BITS_PER_BYTE) begin
            shreg_n   = {shreg[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
            wr_en_n   = (state == WDATA) && (bit_cnt == BITS_PER_BYTE - 4'd1);
          end else if (scl_fall && bit_cnt == BITS_PER_BYTE) begin
            bit_cnt_n = '0;
            sda_oe_n  = I2C_ACK == 1'b0;
            case (state)
              ADDR: begin
                if (shreg[7:1] == TARGET_ADDR) begin
                  rw_n    = shreg[0];
                  busy_n  = 1'b1;
                  state_n = ADDR_ACK;
                end else begin
                  sda_oe_n = 1'b0;
                  busy_n   = 1'b0;
                  state_n  = WAIT_STOP;
                end
              end
              PTR: begin
                ptr_n   = shreg[PTR_W-1:0];
                state_n = PTR_ACK;
              end
              default: state_n = WDATA_ACK;
            endcase
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            if (rw == RW_READ) load_rd = 1'b1;
            else               state_n = PTR;
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            state_n  = WDATA;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == BITS_PER_BYTE) begin
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            state_n   = RDATA_ACK;
          end else if (scl_fall && bit_cnt != 4'd0) begin
            shreg_n  = {shreg[6:0], 1'b0};
            sda_oe_n = ~shreg[6];
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            shreg_n[0] = sda_s;
            bit_cnt_n  = 4'd1;
          end else if (scl_fall && bit_cnt == 4'd1) begin
            if (shreg[0] == I2C_ACK) load_rd = 1'b1;
            else                     state_n = WAIT_STOP;
          end
        end
        IDLE, WAIT_STOP: ;
        default: state_n = IDLE;
      endcase
    end

    // Fetch the next read byte and present its MSB on the bus.
    if (load_rd) begin
      reg_rd_en = ~rst;
      shreg_n   = reg_rdata;
      ptr_n     = ptr + PTR_W'(1);
      sda_oe_n  = ~reg_rdata[7];
      bit_cnt_n = '0;
      state_n   = RDATA;
    end
  end

  assign reg_addr  = ptr;
  assign reg_wdata = shreg;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bit-banged I2C master driving the target, with a register-bank model
// that predicts write strobes, read bytes and the pointer.
module tb_i2c_target_regfile;

  localparam int         DEPTH = 16;
  localparam logic [6:0] TA    = 7'h2A;
  localparam int         Q     = 3;
  localparam int         H     = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, reg_wr_en, reg_rd_en, busy;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;

  logic [7:0]  bank  [DEPTH];
  logic [7:0]  model [DEPTH];
  logic [11:0] obs_q [$];
  logic [11:0] exp_q [$];
  int          mptr = 0;
  int          rd_cnt = 0;
  bit          oe_seen = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign sda_line  = sda_m & ~sda_oe;
  assign reg_rdata = bank[reg_addr];

  i2c_target_regfile #(.TARGET_ADDR(TA), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr_en (reg_wr_en),
    .reg_rdata (reg_rdata),
    .reg_rd_en (reg_rd_en),
    .busy      (busy)
  );

  // The local register bank the target is attached to.
  always @(posedge clk) begin
    if (reg_wr_en) begin
      obs_q.push_back({reg_addr, reg_wdata});
      bank[reg_addr] = reg_wdata;
    end
    if (reg_rd_en) rd_cnt++;
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(H);
    sda_m = 1'b0; tick(H);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(H);
    sda_m = 1'b1; tick(H);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(H);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(H / 2);
    b = sda_line; tick(H / 2);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_wr"}, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_write(input string tag, input logic [7:0] pb, input int n,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input bit do_stop);
    logic       ack;
    logic [7:0] dd [3];
    dd[0] = d0; dd[1] = d1; dd[2] = d2;
    bus_start();
    write_byte({TA, 1'b0}, ack);
    check({tag, "_aack"}, 32'(ack), 32'd0);
    write_byte(pb, ack);
    check({tag, "_pack"}, 32'(ack), 32'd0);
    mptr = int'(pb) % DEPTH;
    for (int i = 0; i < n; i++) begin
      write_byte(dd[i], ack);
      check({tag, "_dack"}, 32'(ack), 32'd0);
      exp_q.push_back({4'(mptr), dd[i]});
      model[mptr] = dd[i];
      mptr = (mptr + 1) % DEPTH;
    end
    if (do_stop) bus_stop();
  endtask

  task automatic do_read(input string tag, input int n);
    logic       ack;
    logic [7:0] d;
    int         rd0;
    rd0 = rd_cnt;
    bus_start();
    write_byte({TA, 1'b1}, ack);
    check({tag, "_raack"}, 32'(ack), 32'd0);
    for (int i = 0; i < n; i++) begin
      read_byte(d, (i == n - 1));
      check({tag, "_rdata"}, 32'(d), 32'(model[mptr]));
      mptr = (mptr + 1) % DEPTH;
    end
    check({tag, "_released"}, 32'(sda_oe), 32'd0);
    bus_stop();
    check({tag, "_nrd"}, 32'(rd_cnt - rd0), 32'(n));
  endtask

  initial begin
    logic ack, b;
    for (int i = 0; i < DEPTH; i++) begin
      bank[i]  = 8'($urandom);
      model[i] = bank[i];
    end
    tick(5);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_wr_en", 32'(reg_wr_en), 32'd0);
    check("rst_rd_en", 32'(reg_rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ptr", 32'(reg_addr), 32'd0);
    rst = 1'b0;
    tick(5);

    // Basic addressed write of two bytes.
    do_write("t1", 8'h03, 2, 8'hA5, 8'h5A, 8'h00, 1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    bus_stop();
    check("t1_busy_stop", 32'(busy), 32'd0);
    compare_writes("t1");
    check("t1_ptr", 32'(reg_addr), 32'(mptr));

    // Pointer byte larger than DEPTH, writes wrap past the top.
    do_write("t2", 8'hFF, 2, 8'h11, 8'h22, 8'h00, 1'b1);
    compare_writes("t2");
    check("t2_ptr", 32'(reg_addr), 32'd1);

    // Pointer set, repeated START, two-byte read ACK then NACK.
    bank[14] = 8'hC3; model[14] = 8'hC3;
    bank[15] = 8'h3C; model[15] = 8'h3C;
    do_write("t3", 8'h0E, 0, 8'h00, 8'h00, 8'h00, 1'b0);
    do_read("t3", 2);
    check("t3_ptr", 32'(reg_addr), 32'(mptr));

    // Foreign address is ignored entirely.
    oe_seen = 1'b0;
    bus_start();
    write_byte(8'h56, ack);
    check("t4_aack", 32'(ack), 32'd1);
    write_byte(8'hFF, ack);
    check("t4_dack", 32'(ack), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    bus_stop();
    check("t4_oe_seen", 32'(oe_seen), 32'd0);
    compare_writes("t4");

    // Reset while the target drives a 0 data bit.
    do_write("t5", 8'h0E, 0, 8'h00, 8'h00, 8'h00, 1'b0);
    bus_start();
    write_byte({TA, 1'b1}, ack);
    check("t5_raack", 32'(ack), 32'd0);
    for (int i = 0; i < 4; i++) read_bit(b);
    check("t5_drive", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    tick(1);
    check("t5_release", 32'(sda_oe), 32'd0);
    rst = 1'b0;
    mptr = 0;
    tick(2);
    bus_start();
    write_byte({TA, 1'b0}, ack);
    check("t5_aack", 32'(ack), 32'd0);
    bus_stop();
    check("t5_ptr", 32'(reg_addr), 32'd0);

    // STOP in the middle of a data byte aborts the write.
    bus_start();
    write_byte({TA, 1'b0}, ack);
    check("t6_aack", 32'(ack), 32'd0);
    write_byte(8'h07, ack);
    check("t6_pack", 32'(ack), 32'd0);
    mptr = 7;
    for (int i = 0; i < 4; i++) write_bit(1'(i));
    bus_stop();
    tick(4);
    compare_writes("t6");
    check("t6_ptr", 32'(reg_addr), 32'(mptr));
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_sda_oe", 32'(sda_oe), 32'd0);

    // Random mix of write and read transactions.
    for (int it = 0; it < 8; it++) begin
      logic [7:0] pb;
      int         n;
      pb = 8'($urandom);
      n  = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 0) begin
        do_write("rw", pb, n, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
      end else begin
        do_write("rr", pb, 0, 8'h00, 8'h00, 8'h00, 1'b0);
        do_read("rr", n);
      end
      compare_writes("rnd");
      check("rnd_ptr", 32'(reg_addr), 32'(mptr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
